// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Write-side companion to the Y86 instruction memory. Takes a
//             byte stream over a valid/ready handshake and writes it one byte
//             per cycle into the memory write port, starting at a
//             programmable base address. Stalls the CPU while busy and
//             reports completion (done pulse) or a sticky error with cause.
//  Option   : IMEM_LOADER_CSUM_EN - when defined, one extra checksum byte
//             follows the program bytes. The 8-bit sum of the program bytes
//             and the checksum byte must be 8'h00.
//  Ports    : clk_i, rst_n_i          clock, async active-low reset
//             start_i, base_i, len_i  load request, base address, length
//             abort_i                 cancel an in-progress load
//             in_valid_i, in_data_i,
//             in_ready_o              byte stream handshake
//             wen_o, waddr_o, wdata_o instruction memory byte write port
//             cpu_stall_o             high whenever the loader is not idle
//             done_o                  one-cycle success pulse
//             error_o, err_code_o     sticky error (1 range, 2 abort, 3 csum)
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int LEN_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [63:0]      base_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             wen_o,
    output logic [63:0]      waddr_o,
    output logic [7:0]       wdata_o,
    output logic             cpu_stall_o,
    output logic             done_o,
    output logic             error_o,
    output logic [1:0]       err_code_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] c_CSUM = 3'd2;
`endif
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    localparam logic [1:0] c_CODE_NONE  = 2'd0;
    localparam logic [1:0] c_CODE_RANGE = 2'd1;
    localparam logic [1:0] c_CODE_ABORT = 2'd2;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [1:0] c_CODE_CSUM  = 2'd3;
`endif

    localparam logic [63:0] c_LAST_ADDR = 64'(MEM_BYTES - 1);
    localparam logic [64:0] c_MEM_END   = 65'(MEM_BYTES);

    logic [2:0]       r_state;
    logic [63:0]      r_addr;
    logic [LEN_W-1:0] r_remain;
    logic             r_wen;
    logic [63:0]      r_waddr;
    logic [7:0]       r_wdata;
    logic [1:0]       r_err_code;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]       r_sum;
    logic [7:0]       w_sum_next;
`endif

    logic             w_in_ready;
    logic             w_accept;
    logic [64:0]      w_end;
    logic             w_range_err;

    // One extra bit keeps base+len from wrapping; base is also compared on
    // its own so a base near 2^64 is always flagged.
    assign w_end       = {1'b0, base_i} + {{(65-LEN_W){1'b0}}, len_i};
    assign w_range_err = (base_i > c_LAST_ADDR) || (w_end > c_MEM_END);

`ifdef IMEM_LOADER_CSUM_EN
    assign w_in_ready = (r_state == c_LOAD) || (r_state == c_CSUM);
    assign w_sum_next = r_sum + in_data_i;
`else
    assign w_in_ready = (r_state == c_LOAD);
`endif

    // Abort wins over a same-cycle byte: that byte is neither accepted nor written.
    assign w_accept = in_valid_i && w_in_ready && !abort_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_err_code <= c_CODE_NONE;
`ifdef IMEM_LOADER_CSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                c_IDLE, c_ERR: begin
                    if (start_i) begin
                        r_err_code <= c_CODE_NONE;
                        if (len_i == '0) begin
                            r_state <= c_DONE;
                        end else if (w_range_err) begin
                            r_state    <= c_ERR;
                            r_err_code <= c_CODE_RANGE;
                        end else begin
                            r_state  <= c_LOAD;
                            r_addr   <= base_i;
                            r_remain <= len_i;
`ifdef IMEM_LOADER_CSUM_EN
                            r_sum    <= '0;
`endif
                        end
                    end
                end
                c_LOAD: begin
                    if (abort_i) begin
                        r_state    <= c_ERR;
                        r_err_code <= c_CODE_ABORT;
                    end else if (w_accept) begin
                        r_wen    <= 1'b1;
                        r_waddr  <= r_addr;
                        r_wdata  <= in_data_i;
                        r_addr   <= r_addr + 64'd1;
                        r_remain <= r_remain - LEN_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
                        r_sum    <= w_sum_next;
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= c_CSUM;
                        end
`else
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= c_DONE;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                c_CSUM: begin
                    // Checksum byte is consumed but never written to memory.
                    if (abort_i) begin
                        r_state    <= c_ERR;
                        r_err_code <= c_CODE_ABORT;
                    end else if (w_accept) begin
                        if (w_sum_next == 8'h00) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state    <= c_ERR;
                            r_err_code <= c_CODE_CSUM;
                        end
                    end
                end
`endif
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign wen_o       = r_wen;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign cpu_stall_o = (r_state != c_IDLE);
    assign done_o      = (r_state == c_DONE);
    assign error_o     = (r_state == c_ERR);
    assign err_code_o  = r_err_code;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the Y86 instruction memory's 64-bit-address, byte-array read port.
- Accepts a byte stream over a valid/ready handshake and writes it byte-by-byte into the instruction memory's write port, starting at a programmable base address.
- Holds the pipeline in stall while loading and reports completion or error.
- Sits between the host/testbench program source and the instruction memory.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes. Valid byte addresses are 0..MEM_BYTES-1.
- LEN_W, 11: width of the transfer length field. Must hold MEM_BYTES.

Ports:
- clk_i  in  1  clock, all state updates on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start-load request. Sampled only in IDLE and ERR.
- base_i  in  64  first byte address of the load. Sampled with start_i.
- len_i  in  LEN_W  number of program bytes. Sampled with start_i.
- abort_i  in  1  cancel an in-progress load.
- in_valid_i  in  1  stream byte valid.
- in_data_i  in  8  stream byte.
- in_ready_o  out  1  loader can accept a byte this cycle.
- wen_o  out  1  instruction memory byte write enable.
- waddr_o  out  64  instruction memory write address.
- wdata_o  out  8  instruction memory write data.
- cpu_stall_o  out  1  high whenever state is not IDLE. Freezes fetch.
- done_o  out  1  one-cycle pulse on successful completion.
- error_o  out  1  sticky error flag.
- err_code_o  out  2  error cause: 0 none, 1 range, 2 abort, 3 checksum.

Behaviour:
- Reset (async, rst_n_i low):
  - state=IDLE.
  - in_ready_o, wen_o, cpu_stall_o, done_o, error_o = 0.
  - waddr_o=0, wdata_o=0, err_code_o=0.
  - Internal addr and remain counters = 0.
  - Reset mid-LOAD abandons the load immediately; no further writes occur.
- States: IDLE, LOAD, CSUM (optional feature only), DONE, ERR.
- IDLE:
  - start_i=1 and len_i=0 -> DONE.
  - start_i=1 and (base_i > MEM_BYTES-1, or base_i+len_i > MEM_BYTES) -> ERR, code 1. Range check uses full 64-bit arithmetic with no wrap: base_i near 2^64 must flag a range error.
  - Otherwise -> LOAD, with addr=base_i and remain=len_i.
- LOAD:
  - in_ready_o=1.
  - Handshake = in_valid_i & in_ready_o.
  - Each handshake, next cycle: wen_o=1, waddr_o=addr, wdata_o=in_data_i. Fixed 1-cycle write latency, one byte per cycle maximum.
  - Each handshake also increments addr and decrements remain.
  - wen_o=0 on cycles with no handshake.
  - Handshake with remain==1 -> DONE (or CSUM if the feature is enabled); in_ready_o drops the next cycle.
  - abort_i=1 -> ERR, code 2. abort_i has priority over a same-cycle handshake: that byte is not accepted and not written.
- DONE: done_o=1 for exactly one cycle, then -> IDLE. The last byte's wen_o pulse coincides with the DONE cycle.
- ERR:
  - error_o=1 and err_code_o held; cpu_stall_o stays 1.
  - start_i re-evaluates exactly as in IDLE and clears error_o/err_code_o when it leaves ERR.
- Data already written before an error or abort stays in memory; nothing is rolled back.
- abort_i in IDLE, DONE or ERR is ignored.
- in_valid_i outside LOAD/CSUM is ignored, and in_ready_o=0 there.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined:
  - After the last program byte, LOAD -> CSUM. in_ready_o=1 and one extra stream byte is accepted.
  - That byte is not written to memory.
  - The running 8-bit sum (mod 256) of all program bytes plus the checksum byte must equal 8'h00.
  - Match -> DONE. Mismatch -> ERR, code 3.
  - abort_i in CSUM -> ERR, code 2.
  - len_i=0 still goes straight to DONE, with no checksum byte.
- Not defined: no CSUM state, no sum register; code 3 is never produced.

Test Plan:
- Load base=0, len=10, bytes 30 F1 F0 DE BC 9A 78 56 34 12 streamed back-to-back:
  - 10 wen_o pulses at addresses 0..9 with matching data.
  - done_o pulses the cycle of the last write.
  - Read port at address 0 returns 80'h123456789ABCDEF0F130.
- Load base=256, len=1, byte 90, with in_valid_i toggling 1-0-1: one write at address 256; in_ready_o stays 1 until acceptance; done_o follows.
- start with base=1020, len=10 -> ERR, error_o=1, err_code_o=1, no writes. Then start with base=1014, len=10 -> loads addresses 1014..1023 and error_o clears.
- Load base=20, len=10, assert abort_i together with the 4th valid byte -> exactly 3 writes (addresses 20..22), err_code_o=2, cpu_stall_o remains 1.
- Deassert rst_n_i mid-load after 5 bytes -> all outputs 0 immediately, without waiting for a clock edge; no later writes.
- With IMEM_LOADER_CSUM_EN, load bytes 60 35 then checksum 6B -> DONE. Repeat with checksum 6C -> err_code_o=3, and bytes 0x60 and 0x35 still written.
